morph_sched: RTL and testbench
==============================

MORPH_SCHED -- requirements
Module: morph_sched

Interface
REQ-001 SHALL have parameter LINE_W, default 10'd512, number of columns counted per line (saturation limit).
REQ-002 SHALL have parameter ROW_MAX, default 10'd767, row counter saturation value.
REQ-003 SHALL have port clk, input, 1, the single clock (video pixel clock); all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fvh, input, 3, {field, vsync, hsync} flags from the NTSC decoder.
REQ-006 SHALL have port dv, input, 1, decoder data-valid strobe.
REQ-007 SHALL have port start, input, 1, host request to begin a morphology job (level-sampled).
REQ-008 SHALL have port abort, input, 1, host request to cancel the current job.
REQ-009 SHALL have port op, input, 2, operation (0 pass-through, 1 dilate, 2 erode, 3 reserved, treated as 0).
REQ-010 SHALL have port passes, input, 4, number of frame passes requested.
REQ-011 SHALL have port busy, output, 1, high in WAIT_FRAME and RUN.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port run, output, 1, datapath enable, high only in RUN.
REQ-014 SHALL have port mode, output, 2, latched op driven to the morphology datapath.
REQ-015 SHALL have port pass_idx, output, 4, index of the current pass.
REQ-016 SHALL have port src_bank, output, 1, ping-pong frame bank to read; the datapath writes !src_bank.
REQ-017 SHALL have port wr_line, output, 2, line buffer being written (0..2).
REQ-018 SHALL have ports mid_line and top_line, outputs, 2 each, line buffers forming rows -1 and -2 of the 3x3 window.
REQ-019 SHALL have ports col and row, outputs, 10 each, current pixel coordinates.
REQ-020 SHALL have port win_valid, output, 1, high when the 3x3 window at (col,row) is complete.

Function
REQ-021 SHALL register fvh[0] and fvh[2] to form hsync_edge (rising fvh[0]) and frame_edge (rising fvh[2]).
REQ-022 SHALL implement FSM states IDLE, WAIT_FRAME, RUN, DONE.
REQ-023 SHALL, in IDLE with start=1, latch op into mode and passes into an internal pass count, with passes=0 latched as 1, then enter WAIT_FRAME.
REQ-024 SHALL, in WAIT_FRAME on frame_edge, enter RUN with pass_idx=0.
REQ-025 SHALL, in RUN on frame_edge, enter DONE when pass_idx equals the pass count minus 1; otherwise it SHALL increment pass_idx, toggle src_bank and stay in RUN.
REQ-026 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE.
REQ-027 SHALL ignore start outside IDLE and SHALL leave mode unchanged while busy.
REQ-028 SHALL, on abort=1 in any state, go to IDLE the next cycle with done=0, run=0 and pass_idx=0; abort SHALL win over start in the same cycle.
REQ-029 SHALL, on frame_edge, clear row to 0, clear col to 0 and clear wr_line to 0.
REQ-030 SHALL, when fvh[0]=1, clear col to 0.
REQ-031 SHALL otherwise increment col when dv=1 and fvh[2:1]=0, saturating at LINE_W-1.
REQ-032 SHALL, on hsync_edge with fvh[2]=0, increment row (saturating at ROW_MAX) and advance wr_line 0->1->2->0.
REQ-033 SHALL, when frame_edge and hsync_edge coincide, apply the frame_edge behaviour only.
REQ-034 SHALL drive mid_line = (wr_line+2) mod 3 and top_line = (wr_line+1) mod 3, combinationally from the registered wr_line.
REQ-035 SHALL drive win_valid = run & dv & ~fvh[2] & ~fvh[1] & (col>=2) & (row>=2), registered with one cycle of latency aligned to col/row.
REQ-036 SHALL run the counters in every state; only run and win_valid are gated by RUN.

Reset
REQ-037 SHALL, while reset_n=0, force state IDLE, busy=0, done=0, run=0, mode=0, pass_idx=0, src_bank=0, wr_line=0, col=0, row=0, win_valid=0 and clear the edge registers.
REQ-038 SHALL, on reset deassertion mid-frame, not start a job until the next start followed by a frame_edge.

Verification
REQ-039 SHALL cover: start with op=1, passes=3 -> run high for exactly 3 frames; pass_idx 0,1,2; src_bank toggles twice; a single done pulse on the cycle after the 3rd frame_edge.
REQ-040 SHALL cover: start with passes=0 -> exactly one RUN frame, then done.
REQ-041 SHALL cover: abort during pass 1 -> IDLE next cycle, no done pulse, and a new start is accepted afterwards.
REQ-042 SHALL cover: 600 dv strobes in one line with LINE_W=512 -> col saturates at 511; hsync -> col=0, row+1, wr_line advances, mid_line/top_line rotate.
REQ-043 SHALL cover: frame_edge coincident with hsync_edge -> row=0 and wr_line=0, no increment.
REQ-044 SHALL cover: win_valid stays 0 for rows 0-1 and cols 0-1, asserts at (2,2) with one cycle of latency, and is 0 outside RUN.

Source files
------------

// File: rtl/morph_sched.sv
// Frame/line scheduler for a 3x3 morphology engine: job FSM over whole video frames,
// ping-pong bank selection, pixel coordinate counters and line-buffer rotation.
module morph_sched #(
  parameter logic [9:0] LINE_W  = 10'd512,
  parameter logic [9:0] ROW_MAX = 10'd767
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] fvh,
  input  logic       dv,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] op,
  input  logic [3:0] passes,
  output logic       busy,
  output logic       done,
  output logic       run,
  output logic [1:0] mode,
  output logic [3:0] pass_idx,
  output logic       src_bank,
  output logic [1:0] wr_line,
  output logic [1:0] mid_line,
  output logic [1:0] top_line,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       win_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [9:0] COL_MAX = LINE_W - 10'd1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_fvh0_q;
  logic       r_fvh2_q;
  logic [1:0] r_mode;
  logic [3:0] r_pass_cnt;
  logic [3:0] r_pass_idx;
  logic       r_src_bank;
  logic [1:0] r_wr_line;
  logic [9:0] r_col;
  logic [9:0] r_row;
  logic       r_win_valid;

  logic       w_hsync_edge;
  logic       w_frame_edge;
  logic       w_last_pass;
  logic       w_run;
  logic       w_win_now;

  assign w_hsync_edge = fvh[0] & ~r_fvh0_q;
  assign w_frame_edge = fvh[2] & ~r_fvh2_q;
  assign w_last_pass  = (r_pass_idx == r_pass_cnt - 4'd1);
  assign w_run        = (r_state == S_RUN);

  // NOTE: every always_ff uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_fvh0_q <= 1'b0;
      r_fvh2_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fvh0_q <= fvh[0];
      r_fvh2_q <= fvh[2];
    end
  end

  // NOTE: the default assignment ahead of the case keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (start) w_state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: if (w_frame_edge) w_state_nxt = S_RUN;
      S_RUN:        if (w_frame_edge && w_last_pass) w_state_nxt = S_DONE;
      S_DONE:       w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // Job registers: op/passes are captured only on acceptance, so they stay frozen while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= 2'd0;
      r_pass_cnt <= 4'd1;
      r_pass_idx <= 4'd0;
      r_src_bank <= 1'b0;
    end else if (abort) begin
      r_pass_idx <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode     <= (op == 2'd3) ? 2'd0 : op;
            r_pass_cnt <= (passes == 4'd0) ? 4'd1 : passes;
            r_pass_idx <= 4'd0;
          end
        end
        S_WAIT_FRAME: if (w_frame_edge) r_pass_idx <= 4'd0;
        S_RUN: begin
          if (w_frame_edge && !w_last_pass) begin
            r_pass_idx <= r_pass_idx + 4'd1;
            r_src_bank <= ~r_src_bank;
          end
        end
        S_DONE:  r_pass_idx <= 4'd0;
        default: r_pass_idx <= 4'd0;
      endcase
    end
  end

  // Coordinate counters run in every state; a frame edge overrides a coincident hsync edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col     <= 10'd0;
      r_row     <= 10'd0;
      r_wr_line <= 2'd0;
    end else if (w_frame_edge) begin
      r_col     <= 10'd0;
      r_row     <= 10'd0;
      r_wr_line <= 2'd0;
    end else begin
      if (fvh[0]) begin
        r_col <= 10'd0;
      end else if (dv && (fvh[2:1] == 2'b00) && (r_col < COL_MAX)) begin
        r_col <= r_col + 10'd1;
      end
      if (w_hsync_edge && !fvh[2]) begin
        if (r_row < ROW_MAX) r_row <= r_row + 10'd1;
        r_wr_line <= (r_wr_line == 2'd2) ? 2'd0 : r_wr_line + 2'd1;
      end
    end
  end

  assign w_win_now = w_run & dv & ~fvh[2] & ~fvh[1] & (r_col >= 10'd2) & (r_row >= 10'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_win_valid <= 1'b0;
    else          r_win_valid <= w_win_now;
  end

  always_comb begin
    mid_line = 2'd0;
    top_line = 2'd0;
    case (r_wr_line)
      2'd0:    begin mid_line = 2'd2; top_line = 2'd1; end
      2'd1:    begin mid_line = 2'd0; top_line = 2'd2; end
      2'd2:    begin mid_line = 2'd1; top_line = 2'd0; end
      default: begin mid_line = 2'd0; top_line = 2'd0; end
    endcase
  end

  assign busy      = (r_state == S_WAIT_FRAME) || (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign run       = w_run;
  assign mode      = r_mode;
  assign pass_idx  = r_pass_idx;
  assign src_bank  = r_src_bank;
  assign wr_line   = r_wr_line;
  assign col       = r_col;
  assign row       = r_row;
  assign win_valid = r_win_valid;

endmodule

// File: tb/tb_morph_sched.sv
// Directed bench for morph_sched: table-driven job FSM vectors plus hand-written
// sequences for counter saturation, line rotation, edge coincidence and window validity.
module tb_morph_sched;

  logic       clk;
  logic       reset_n;
  logic [2:0] fvh;
  logic       dv;
  logic       start;
  logic       abort;
  logic [1:0] op;
  logic [3:0] passes;
  logic       busy;
  logic       done;
  logic       run;
  logic [1:0] mode;
  logic [3:0] pass_idx;
  logic       src_bank;
  logic [1:0] wr_line;
  logic [1:0] mid_line;
  logic [1:0] top_line;
  logic [9:0] col;
  logic [9:0] row;
  logic       win_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int m_col;
  int m_row;

  typedef struct {
    logic [2:0] fvh;
    logic       start;
    logic       abort;
    logic [1:0] op;
    logic [3:0] passes;
    logic       e_busy;
    logic       e_done;
    logic       e_run;
    logic [1:0] e_mode;
    logic [3:0] e_pidx;
    logic       e_src;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl[NVEC];

  morph_sched #(.LINE_W(10'd512), .ROW_MAX(10'd767)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .fvh      (fvh),
    .dv       (dv),
    .start    (start),
    .abort    (abort),
    .op       (op),
    .passes   (passes),
    .busy     (busy),
    .done     (done),
    .run      (run),
    .mode     (mode),
    .pass_idx (pass_idx),
    .src_bank (src_bank),
    .wr_line  (wr_line),
    .mid_line (mid_line),
    .top_line (top_line),
    .col      (col),
    .row      (row),
    .win_valid(win_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic [2:0] f, input logic s, input logic a,
                             input logic [1:0] o, input logic [3:0] p,
                             input logic eb, input logic ed, input logic er,
                             input logic [1:0] em, input logic [3:0] ep, input logic es);
    vec_t t;
    t.fvh = f; t.start = s; t.abort = a; t.op = o; t.passes = p;
    t.e_busy = eb; t.e_done = ed; t.e_run = er; t.e_mode = em; t.e_pidx = ep; t.e_src = es;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic win_lines(input bit run_m);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        logic exp_wv;
        dv = 1'b1;
        exp_wv = run_m && (m_col >= 2) && (m_row >= 2);
        tick();
        check($sformatf("win_valid r%0d c%0d run%0d", m_row, m_col, run_m), win_valid, exp_wv);
        m_col++;
      end
      dv = 1'b0; fvh = 3'b001;
      tick();
      check($sformatf("win_valid drop r%0d", m_row), win_valid, 1'b0);
      fvh = 3'b000;
      tick();
      m_row++;
      m_col = 0;
    end
  endtask

  initial begin
    // Job 1: op=1, passes=3 (start re-asserted mid-job with a new op must be ignored)
    tbl[0]  = v(3'b000, 1, 0, 2'd1, 4'd3,  1, 0, 0, 2'd1, 4'd0, 0);
    tbl[1]  = v(3'b000, 0, 0, 2'd1, 4'd3,  1, 0, 0, 2'd1, 4'd0, 0);
    tbl[2]  = v(3'b100, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd1, 4'd0, 0);
    tbl[3]  = v(3'b000, 1, 0, 2'd2, 4'd5,  1, 0, 1, 2'd1, 4'd0, 0);
    tbl[4]  = v(3'b100, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd1, 4'd1, 1);
    tbl[5]  = v(3'b000, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd1, 4'd1, 1);
    tbl[6]  = v(3'b100, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd1, 4'd2, 0);
    tbl[7]  = v(3'b000, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd1, 4'd2, 0);
    tbl[8]  = v(3'b100, 0, 0, 2'd0, 4'd0,  0, 1, 0, 2'd1, 4'd2, 0);
    tbl[9]  = v(3'b000, 0, 0, 2'd0, 4'd0,  0, 0, 0, 2'd1, 4'd0, 0);
    // Job 2: passes=0 behaves as a single pass
    tbl[10] = v(3'b000, 1, 0, 2'd0, 4'd0,  1, 0, 0, 2'd0, 4'd0, 0);
    tbl[11] = v(3'b100, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd0, 4'd0, 0);
    tbl[12] = v(3'b000, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd0, 4'd0, 0);
    tbl[13] = v(3'b100, 0, 0, 2'd0, 4'd0,  0, 1, 0, 2'd0, 4'd0, 0);
    tbl[14] = v(3'b000, 0, 0, 2'd0, 4'd0,  0, 0, 0, 2'd0, 4'd0, 0);
    // Job 3: abort in pass 1 wins over a simultaneous start
    tbl[15] = v(3'b000, 1, 0, 2'd2, 4'd4,  1, 0, 0, 2'd2, 4'd0, 0);
    tbl[16] = v(3'b100, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd2, 4'd0, 0);
    tbl[17] = v(3'b000, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd2, 4'd0, 0);
    tbl[18] = v(3'b100, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd2, 4'd1, 1);
    tbl[19] = v(3'b000, 1, 1, 2'd1, 4'd2,  0, 0, 0, 2'd2, 4'd0, 1);
    tbl[20] = v(3'b000, 0, 0, 2'd0, 4'd0,  0, 0, 0, 2'd2, 4'd0, 1);
    // Job 4: accepted after abort; reserved op=3 maps to pass-through
    tbl[21] = v(3'b000, 1, 0, 2'd3, 4'd1,  1, 0, 0, 2'd0, 4'd0, 1);
    tbl[22] = v(3'b100, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd0, 4'd0, 1);
    tbl[23] = v(3'b000, 0, 0, 2'd0, 4'd0,  1, 0, 1, 2'd0, 4'd0, 1);
    tbl[24] = v(3'b100, 0, 0, 2'd0, 4'd0,  0, 1, 0, 2'd0, 4'd0, 1);
    tbl[25] = v(3'b000, 0, 0, 2'd0, 4'd0,  0, 0, 0, 2'd0, 4'd0, 1);

    reset_n = 1'b0;
    fvh = 3'b000; dv = 1'b0; start = 1'b0; abort = 1'b0; op = 2'd0; passes = 4'd0;
    repeat (3) @(negedge clk);
    check("reset fsm {busy,done,run,mode,pidx,src}",
          {busy, done, run, mode, pass_idx, src_bank}, 10'd0);
    check("reset counters {wr_line,col,row,win_valid}", {wr_line, col, row, win_valid}, 23'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      fvh = tbl[i].fvh; start = tbl[i].start; abort = tbl[i].abort;
      op = tbl[i].op; passes = tbl[i].passes; dv = 1'b0;
      tick();
      check($sformatf("fsm vec %0d {busy,done,run,mode,pidx,src}", i),
            {busy, done, run, mode, pass_idx, src_bank},
            {tbl[i].e_busy, tbl[i].e_done, tbl[i].e_run, tbl[i].e_mode, tbl[i].e_pidx, tbl[i].e_src});
    end
    start = 1'b0; abort = 1'b0; op = 2'd0; passes = 4'd0;
    check("counters after frame edge {col,row,wr_line}", {col, row, wr_line}, 22'd0);

    // Column saturation over a long line
    fvh = 3'b000; dv = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (i == 299) check("col mid-line", col, 10'd300);
    end
    check("col saturated", col, 10'd511);

    // Hsync: col clears, row advances, line buffers rotate
    fvh = 3'b001;
    tick();
    check("hsync 1 {col,row,wr,mid,top}", {col, row, wr_line, mid_line, top_line},
          {10'd0, 10'd1, 2'd1, 2'd0, 2'd2});
    tick();
    check("hsync held, dv high {col,row}", {col, row}, {10'd0, 10'd1});
    dv = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      logic [1:0] e_wr, e_mid, e_top;
      e_wr = 2'(k % 3); e_mid = 2'((k + 2) % 3); e_top = 2'((k + 1) % 3);
      fvh = 3'b000; tick();
      fvh = 3'b001; tick();
      check($sformatf("hsync %0d {col,row,wr,mid,top}", k), {col, row, wr_line, mid_line, top_line},
            {10'd0, 10'(k), e_wr, e_mid, e_top});
    end

    // Frame edge coincident with hsync edge: frame behaviour only
    fvh = 3'b000; tick();
    fvh = 3'b101; tick();
    check("frame+hsync coincide {col,row,wr}", {col, row, wr_line}, 22'd0);

    // Window validity inside a single-pass RUN, then outside RUN
    fvh = 3'b000; start = 1'b1; op = 2'd1; passes = 4'd1;
    tick();
    start = 1'b0;
    fvh = 3'b100; tick();
    check("win job running", run, 1'b1);
    fvh = 3'b000; tick();
    m_col = 0; m_row = 0;
    win_lines(1'b1);
    fvh = 3'b100; tick();
    check("win job done pulse", done, 1'b1);
    fvh = 3'b000; tick();
    check("win job idle {busy,run,done}", {busy, run, done}, 3'b000);
    m_col = 0; m_row = 0;
    win_lines(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
